// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags,
// overflow/underflow pulses and selectable first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_en,
  output logic [DATA_W-1:0] out,
  output logic              mem_full,
  output logic              mem_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_TH = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_TH = AEMPTY_TH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic              wr_ok;
  logic              rd_ok;

  // Status is derived from registered pointers only.
  assign count = wptr - rptr;
  assign mem_empty = (wptr == rptr);
  assign mem_full =
    (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) &&
    (wptr[ADDR_W] != rptr[ADDR_W]);
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  assign wr_ok = write_en && !mem_full;
  assign rd_ok = read_en && !mem_empty;

  always_ff @(posedge clk) begin
    if (wr_ok && !reset) begin
      mem[wptr[ADDR_W-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
      end
      overflow  <= write_en && mem_full;
      underflow <= read_en && mem_empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign out = mem_empty ? '0 : mem[rptr[ADDR_W-1:0]];
    end else begin : g_reg
      logic [DATA_W-1:0] out_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          out_q <= '0;
        end else if (rd_ok) begin
          out_q <= mem[rptr[ADDR_W-1:0]];
        end
      end

      assign out = out_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench: registered-read and FWFT instances share one stimulus
// stream and are checked against a queue-based occupancy model.
module tb_sync_fifo_param;

  localparam int DEPTH = 8;

  typedef struct {
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ov;
    logic       un;
    logic [7:0] o0;
    logic [7:0] o1;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       write_en;
  logic       read_en;
  logic [7:0] data_in;

  logic [7:0] out0, out1;
  logic       full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1;
  logic [3:0] cnt0, cnt1;
  logic       ov0, ov1, un0, un1;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  logic [7:0] m_out0;
  int         n_vec;
  int         n_fail;
  bit         done;

  sync_fifo_param #(
    .DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)
  ) dut0 (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .out(out0), .mem_full(full0), .mem_empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ov0), .underflow(un0)
  );

  sync_fifo_param #(
    .DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)
  ) dut1 (
    .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .out(out1), .mem_full(full1), .mem_empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ov1), .underflow(un1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Reference: a plain queue of words plus the last registered read value.
  task automatic step(bit rst, bit we, bit re, logic [7:0] d);
    exp_t e;
    bit   rd;
    bit   wr;
    @(negedge clk);
    reset    = rst;
    write_en = we;
    read_en  = re;
    data_in  = d;
    if (rst) begin
      mq.delete();
      m_out0 = 8'h00;
      e.ov   = 1'b0;
      e.un   = 1'b0;
    end else begin
      e.ov = we && (mq.size() == DEPTH);
      e.un = re && (mq.size() == 0);
      rd   = re && (mq.size() > 0);
      wr   = we && (mq.size() < DEPTH);
      if (rd) m_out0 = mq.pop_front();
      if (wr) mq.push_back(d);
    end
    e.cnt   = 4'(mq.size());
    e.full  = (mq.size() == DEPTH);
    e.empty = (mq.size() == 0);
    e.af    = (mq.size() >= 6);
    e.ae    = (mq.size() <= 1);
    e.o0    = m_out0;
    e.o1    = (mq.size() > 0) ? mq[0] : 8'h00;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge presents a new state; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count0", 32'(cnt0), 32'(e.cnt));
        chk("count1", 32'(cnt1), 32'(e.cnt));
        chk("full0", 32'(full0), 32'(e.full));
        chk("full1", 32'(full1), 32'(e.full));
        chk("empty0", 32'(empty0), 32'(e.empty));
        chk("empty1", 32'(empty1), 32'(e.empty));
        chk("afull0", 32'(af0), 32'(e.af));
        chk("afull1", 32'(af1), 32'(e.af));
        chk("aempty0", 32'(ae0), 32'(e.ae));
        chk("aempty1", 32'(ae1), 32'(e.ae));
        chk("ovf0", 32'(ov0), 32'(e.ov));
        chk("ovf1", 32'(ov1), 32'(e.ov));
        chk("udf0", 32'(un0), 32'(e.un));
        chk("udf1", 32'(un1), 32'(e.un));
        chk("out_reg", 32'(out0), 32'(e.o0));
        chk("out_fwft", 32'(out1), 32'(e.o1));
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    n_vec    = 0;
    n_fail   = 0;
    done     = 1'b0;
    m_out0   = 8'h00;
    reset    = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    data_in  = 8'h00;

    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    // fill, overflow, drain, underflow
    for (int i = 0; i < 8; i++) step(0, 1, 0, 8'(8'h10 + i));
    step(0, 1, 0, 8'hAA);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // steady simultaneous traffic at count 4, pointers wrap repeatedly
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) step(0, 1, 1, 8'($urandom));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);

    // fall-through of a single word, then write+read while empty
    step(0, 1, 0, 8'h5C);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'h3E);
    step(0, 0, 1, 8'h00);

    // reset with a write pending while five words are buffered
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h60 + i));
    step(1, 1, 0, 8'hEE);
    step(0, 1, 0, 8'h77);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // random traffic, write-biased then read-biased, rare resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) == 0),
           (i < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           8'($urandom));
    end
    step(0, 0, 0, 8'h00);

    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the same-clock successor to the dual-clock 8x8 FIFO. Width, depth and almost-thresholds are generic. It adds an occupancy count, almost-full/almost-empty flags, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. It is used inside one clock domain wherever a stage needs elastic buffering, so no Gray-code synchronisers are needed.

## Interface
Parameters:
- DATA_W, default 8: word width in bits; must be >= 1.
- ADDR_W, default 3: address width; DEPTH = 2**ADDR_W; must be >= 1.
- AFULL_TH, default 6: almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, default 1: almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.
- FWFT, default 0: read mode. 0 = registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- write_en  in  1  write request.
- data_in  in  DATA_W  write data.
- read_en  in  1  read request (FWFT=1: pop the head word).
- out  out  DATA_W  read data.
- mem_full  out  1  count == DEPTH.
- mem_empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ADDR_W+1  current occupancy, range 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.

## Operation
- Storage: DEPTH x DATA_W array; no reset of its contents.
- Pointers:
  - wptr and rptr are ADDR_W+1-bit binary pointers, modulo 2**(ADDR_W+1).
  - The low ADDR_W bits address the array; the MSB is the wrap bit.
- count = wptr - rptr, computed in ADDR_W+1 bits.
- Flags:
  - mem_full: pointer low bits equal and wrap bits differ.
  - mem_empty: pointers equal.
  - All four status flags are combinational from registered pointers only, never from this cycle's requests.
- Write acceptance:
  - A write is accepted iff write_en && !mem_full.
  - When accepted: mem[wptr[ADDR_W-1:0]] <= data_in, then wptr increments.
- Read acceptance:
  - A read is accepted iff read_en && !mem_empty.
  - When accepted: rptr increments.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
  - When full, the write is still rejected even if a read is accepted in the same cycle.
  - When empty, the read is still rejected even if a write is accepted in the same cycle.
- FWFT=0:
  - On an accepted read, out <= mem[rptr[ADDR_W-1:0]].
  - Otherwise out holds its value.
- FWFT=1:
  - out = mem[rptr[ADDR_W-1:0]] combinationally while !mem_empty.
  - out = 0 while mem_empty.
  - An accepted read exposes the next word.
- overflow is registered: high for one cycle after an edge where write_en && mem_full.
- underflow is registered: high for one cycle after an edge where read_en && mem_empty.
- Rejected requests change no pointer, no array entry and no out value.
- Reset (sync, high), values after the edge where reset is sampled:
  - wptr = 0, rptr = 0, count = 0.
  - out = 0, overflow = 0, underflow = 0.
  - mem_empty = 1, almost_empty = 1, mem_full = 0, almost_full = 0.
  - Reset dominates any simultaneous write_en or read_en.
  - Reset asserted mid-operation discards all buffered words.

## Timing
- Write accepted at edge k:
  - count, mem_empty and almost flags reflect the write after edge k.
  - The earliest accepted read of that word is at edge k+1.
- FWFT=0: data appears on out after the edge where the read is accepted, i.e. 1-cycle read latency; back-to-back reads give one word per cycle.
- FWFT=1: the word written at edge k is on out after edge k when the FIFO was empty; read latency is 0.
- Throughput: one write and one read per cycle, sustained.
- Full/empty have no look-ahead: a write at edge k that fills the FIFO raises mem_full after edge k, so the write at edge k+1 is rejected.
- Wrap-around: pointer roll-over from 2**(ADDR_W+1)-1 to 0 is seamless; count stays correct.

## Test plan
- Fill/drain (DATA_W=8, ADDR_W=3, FWFT=0):
  - Stimulus: reset, then write 0x10..0x17 on 8 consecutive cycles.
  - Required: mem_full=1 and count=8; after 8 reads out sequences 0x10..0x17, each one cycle after its read; then mem_empty=1.
- Overflow/underflow:
  - Stimulus: when full, write 0xAA.
  - Required: overflow pulses for exactly 1 cycle; count stays 8; 0xAA is never read.
  - Stimulus: when empty, read.
  - Required: underflow pulses for 1 cycle; out unchanged.
- Simultaneous read and write at count=4 for 20 cycles:
  - Required: count stays 4; pointers wrap at least twice; data order preserved.
- Thresholds (AFULL_TH=6, AEMPTY_TH=1):
  - Required: almost_full rises after the 6th write and falls after the read taking count to 5; almost_empty=1 at count 0 and 1, and 0 at count 2.
- FWFT=1:
  - Stimulus: write 0x5C to an empty FIFO.
  - Required: out=0x5C in the next cycle with no read; popping it gives out=0 and mem_empty=1.
- Reset mid-stream:
  - Stimulus: with count=5, assert reset for 1 cycle together with write_en=1.
  - Required: count=0, mem_empty=1, out=0; the write is ignored; the next word written is the first word read.
